// File: rtl/exception_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg : shared types and constants for the LEGv8 exception responder.
//
// Contents:
//   excState_t     - responder state (NORMAL, HANDLER, FAULT)
//   ESR_*          - exception syndrome codes stored in ESR
//   SEL_*          - MRS system-register select encodings
//   isSyncFault()  - true when the decoder reports a synchronous exception
// ---------------------------------------------------------------------------
package exc_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    HANDLER = 2'b01,
    FAULT   = 2'b10
  } excState_t;

  localparam logic [3:0] ESR_NONE   = 4'h0;
  localparam logic [3:0] ESR_IRQ    = 4'h1;
  localparam logic [3:0] ESR_INVOP  = 4'h2;
  localparam logic [3:0] ESR_DFAULT = 4'hF;

  localparam logic [1:0] SEL_ELR   = 2'b00;
  localparam logic [1:0] SEL_ESR   = 2'b01;
  localparam logic [1:0] SEL_COUNT = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

  // Any non-zero code from the decoder is a synchronous exception
  function automatic logic isSyncFault(input logic [3:0] eStatus);
    return eStatus != ESR_NONE;
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// ---------------------------------------------------------------------------
// exception_ctrl_if : signal bundle between the core datapath and the
// exception responder.
//
// Core -> responder : EStatus, ERet, PC, irq_req, sysreg_sel
// Responder -> core : irq_ack, Exc, ExcFlush, ExcVector, ELR, ESR,
//                     InHandler, sysreg_rd
// Modports:
//   master - the core/decoder side
//   slave  - the exception_ctrl side
// ---------------------------------------------------------------------------
interface exception_ctrl_if #(
  parameter int N = 64
) ();

  logic [3:0]   EStatus;
  logic         ERet;
  logic [N-1:0] PC;
  logic         irq_req;
  logic         irq_ack;
  logic         Exc;
  logic         ExcFlush;
  logic [N-1:0] ExcVector;
  logic [N-1:0] ELR;
  logic [3:0]   ESR;
  logic         InHandler;
  logic [1:0]   sysreg_sel;
  logic [N-1:0] sysreg_rd;

  modport master (
    output EStatus, ERet, PC, irq_req, sysreg_sel,
    input  irq_ack, Exc, ExcFlush, ExcVector, ELR, ESR, InHandler, sysreg_rd
  );

  modport slave (
    input  EStatus, ERet, PC, irq_req, sysreg_sel,
    output irq_ack, Exc, ExcFlush, ExcVector, ELR, ESR, InHandler, sysreg_rd
  );

endinterface

// File: rtl/exception_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous active-low clear
//   inc    in  1  add one at the next edge (ignored once saturated)
//   count  out W  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on request; hold at all-ones so software never sees a wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// ---------------------------------------------------------------------------
// exception_ctrl : exception responder for the single-cycle LEGv8 core.
//
// Takes synchronous exceptions (EStatus != 0) and, optionally, an external
// level interrupt. Taking an exception redirects the PC to EXC_VECTOR,
// flushes the current instruction and records ELR/ESR. A second fault while
// in the handler locks the responder in FAULT until reset.
//
// Ports:
//   clk    in  1  core clock, rising edge
//   reset  in  1  asynchronous active-low reset
//   bus    slave modport of exception_ctrl_if (EStatus, ERet, PC, irq_req,
//          sysreg_sel in; irq_ack, Exc, ExcFlush, ExcVector, ELR, ESR,
//          InHandler, sysreg_rd out)
//
// Build option:
//   EXC_IRQ_EN - when defined, irq_req is serviced in NORMAL state and
//                acknowledged with irq_ack. When undefined the interrupt
//                input is ignored and irq_ack is tied low.
// ---------------------------------------------------------------------------
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int           N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
  parameter int           CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  exception_ctrl_if.slave  bus
);

  excState_t      state;
  logic [N-1:0]   elr;
  logic [3:0]     esr;
  logic           irqAck;
  logic [CNT_W-1:0] count;

  logic syncReq;
  logic irqReq;
  logic takeNormal;
  logic takeIrq;
  logic doubleFault;
  logic excComb;

  assign syncReq = isSyncFault(bus.EStatus);

`ifdef EXC_IRQ_EN
  assign irqReq = bus.irq_req;
`else
  logic unusedIrq;
  assign unusedIrq = bus.irq_req;
  assign irqReq    = 1'b0;
`endif

  // Decide this cycle's redirect. IRQs are only considered in NORMAL, and a
  // sync fault wins over a simultaneous IRQ, leaving the IRQ pending.
  always_comb begin
    takeNormal  = 1'b0;
    doubleFault = 1'b0;
    excComb     = 1'b0;
    unique case (state)
      NORMAL: begin
        takeNormal = syncReq | irqReq;
        excComb    = takeNormal;
      end
      HANDLER: begin
        doubleFault = syncReq;
        excComb     = doubleFault;
      end
      default: begin
        excComb = 1'b1;
      end
    endcase
  end

  assign takeIrq = takeNormal & ~syncReq;

  // Responder FSM plus the ELR/ESR/ack registers it owns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= NORMAL;
      elr    <= '0;
      esr    <= ESR_NONE;
      irqAck <= 1'b0;
    end else begin
      irqAck <= 1'b0;
      unique case (state)
        NORMAL: begin
          if (takeNormal) begin
            elr    <= bus.PC;
            esr    <= syncReq ? bus.EStatus : ESR_IRQ;
            irqAck <= takeIrq;
            state  <= HANDLER;
          end
        end
        HANDLER: begin
          if (doubleFault) begin
            esr   <= ESR_DFAULT;
            state <= FAULT;
          end else if (bus.ERet) begin
            state <= NORMAL;
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_count (
    .clk   (clk),
    .reset (reset),
    .inc   (takeNormal),
    .count (count)
  );

  // MRS read port: reads registered values only, zero-extended to N
  always_comb begin
    bus.sysreg_rd = '0;
    unique case (bus.sysreg_sel)
      SEL_ELR:   bus.sysreg_rd = elr;
      SEL_ESR:   bus.sysreg_rd = {{(N-4){1'b0}}, esr};
      SEL_COUNT: bus.sysreg_rd = {{(N-CNT_W){1'b0}}, count};
      default:   bus.sysreg_rd = '0;
    endcase
  end

  // Redirect is forced low while reset is asserted, even with EStatus set
  assign bus.Exc       = reset & excComb;
  assign bus.ExcFlush  = reset & excComb;
  assign bus.ExcVector = EXC_VECTOR;
  assign bus.ELR       = elr;
  assign bus.ESR       = esr;
  assign bus.InHandler = (state == HANDLER);
  assign bus.irq_ack   = irqAck;

endmodule

// File: tb/tb_exception_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exception_ctrl : self-checking bench for exception_ctrl.
// The DUT is built with CNT_W=2 so counter saturation is reachable.
// Honours EXC_IRQ_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_exception_ctrl;

  localparam int          N   = 64;
  localparam int          CW  = 2;
  localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;
`ifdef EXC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   numCompared   = 0;
  int   numMismatched = 0;

  always #5 clk = ~clk;

  exception_ctrl_if #(.N(N)) bus ();

  exception_ctrl #(
    .N          (N),
    .EXC_VECTOR (VEC),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: "in handler" / "faulted" flags, saved registers, count
  bit          mHandler;
  bit          mFault;
  bit          mAck;
  logic [63:0] mElr;
  logic [3:0]  mEsr;
  int          mCount;

  function automatic bit expExc();
    if (mFault)   return 1'b1;
    if (mHandler) return bus.EStatus != 4'd0;
    return (bus.EStatus != 4'd0) || (IRQ_EN && bus.irq_req);
  endfunction

  function automatic logic [63:0] expSys(input logic [1:0] sel);
    case (sel)
      2'd0:    return mElr;
      2'd1:    return {60'd0, mEsr};
      2'd2:    return 64'(mCount);
      default: return 64'd0;
    endcase
  endfunction

  function automatic void clearModel();
    mHandler = 0; mFault = 0; mAck = 0; mElr = '0; mEsr = '0; mCount = 0;
  endfunction

  task automatic applyStimulus(input logic [3:0] es, input logic er,
                               input logic [63:0] pc, input logic irq,
                               input logic [1:0] sel);
    bus.EStatus = es; bus.ERet = er; bus.PC = pc;
    bus.irq_req = irq; bus.sysreg_sel = sel;
  endtask

  // One rising edge; the model follows the rules applied to the held inputs
  task automatic advanceClock();
    @(posedge clk);
    if (mFault) begin
      mAck = 0;
    end else if (mHandler) begin
      mAck = 0;
      if (bus.EStatus != 0) begin
        mEsr = 4'hF; mFault = 1; mHandler = 0;
      end else if (bus.ERet) begin
        mHandler = 0;
      end
    end else if (bus.EStatus != 0 || (IRQ_EN && bus.irq_req)) begin
      mElr = bus.PC;
      mEsr = (bus.EStatus != 0) ? bus.EStatus : 4'd1;
      if (mCount < (1 << CW) - 1) mCount++;
      mHandler = 1;
      mAck = (bus.EStatus == 0);
    end else begin
      mAck = 0;
    end
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    clearModel();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    applyStimulus(4'd2, 1'b0, 64'h1000, 1'b0, 2'd0);
    advanceClock();
    applyStimulus(4'd2, 1'b0, 64'h2000, 1'b1, 2'd0);
    #1;
    reset = 1'b0;
    clearModel();
    #1;
    numCompared++; if (bus.Exc !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_exc got=%b want=0", bus.Exc); end
    numCompared++; if (bus.ExcFlush !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_flush got=%b want=0", bus.ExcFlush); end
    numCompared++; if (bus.InHandler !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_inhandler got=%b want=0", bus.InHandler); end
    numCompared++; if (bus.irq_ack !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_ack got=%b want=0", bus.irq_ack); end
    numCompared++; if (bus.ELR !== 64'd0) begin numMismatched++; $display("[TB] FAIL reset_elr got=%h want=0", bus.ELR); end
    numCompared++; if (bus.sysreg_rd !== 64'd0) begin numMismatched++; $display("[TB] FAIL reset_sysreg got=%h want=0", bus.sysreg_rd); end
    applyStimulus(4'd0, 1'b0, 64'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_sync_exception();
    doReset();
    applyStimulus(4'd2, 1'b0, 64'h40, 1'b0, 2'd2);
    #2;
    numCompared++; if (bus.Exc !== 1'b1) begin numMismatched++; $display("[TB] FAIL sync_exc got=%b want=1", bus.Exc); end
    numCompared++; if (bus.ExcFlush !== 1'b1) begin numMismatched++; $display("[TB] FAIL sync_flush got=%b want=1", bus.ExcFlush); end
    numCompared++; if (bus.ExcVector !== VEC) begin numMismatched++; $display("[TB] FAIL sync_vector got=%h want=%h", bus.ExcVector, VEC); end
    advanceClock();
    applyStimulus(4'd0, 1'b0, 64'hD8, 1'b0, 2'd2);
    #2;
    numCompared++; if (bus.ELR !== 64'h40) begin numMismatched++; $display("[TB] FAIL sync_elr got=%h want=40", bus.ELR); end
    numCompared++; if (bus.ESR !== 4'd2) begin numMismatched++; $display("[TB] FAIL sync_esr got=%h want=2", bus.ESR); end
    numCompared++; if (bus.InHandler !== 1'b1) begin numMismatched++; $display("[TB] FAIL sync_inhandler got=%b want=1", bus.InHandler); end
    numCompared++; if (bus.sysreg_rd !== 64'd1) begin numMismatched++; $display("[TB] FAIL sync_count got=%h want=1", bus.sysreg_rd); end
    numCompared++; if (bus.Exc !== 1'b0) begin numMismatched++; $display("[TB] FAIL sync_handler_exc got=%b want=0", bus.Exc); end
  endtask

  task automatic test_eret();
    // Continues from the handler entered by test_sync_exception
    applyStimulus(4'd0, 1'b1, 64'hE0, 1'b0, 2'd0);
    #2;
    numCompared++; if (bus.sysreg_rd !== 64'h40) begin numMismatched++; $display("[TB] FAIL eret_target got=%h want=40", bus.sysreg_rd); end
    advanceClock();
    numCompared++; if (bus.InHandler !== 1'b0) begin numMismatched++; $display("[TB] FAIL eret_exit got=%b want=0", bus.InHandler); end
    applyStimulus(4'd0, 1'b1, 64'h44, 1'b0, 2'd1);
    advanceClock();
    #1;
    numCompared++; if (bus.InHandler !== 1'b0) begin numMismatched++; $display("[TB] FAIL eret_normal_state got=%b want=0", bus.InHandler); end
    numCompared++; if (bus.ELR !== 64'h40) begin numMismatched++; $display("[TB] FAIL eret_normal_elr got=%h want=40", bus.ELR); end
    numCompared++; if (bus.sysreg_rd !== 64'd2) begin numMismatched++; $display("[TB] FAIL eret_normal_esr got=%h want=2", bus.sysreg_rd); end
  endtask

  task automatic test_irq_pending();
    doReset();
    applyStimulus(4'd2, 1'b0, 64'h80, 1'b1, 2'd1);
    #2;
    numCompared++; if (bus.Exc !== 1'b1) begin numMismatched++; $display("[TB] FAIL irqsync_exc got=%b want=1", bus.Exc); end
    advanceClock();
    applyStimulus(4'd0, 1'b1, 64'hD8, 1'b1, 2'd1);
    #2;
    numCompared++; if (bus.sysreg_rd !== 64'd2) begin numMismatched++; $display("[TB] FAIL irqsync_esr got=%h want=2", bus.sysreg_rd); end
    numCompared++; if (bus.irq_ack !== 1'b0) begin numMismatched++; $display("[TB] FAIL irqsync_ack got=%b want=0", bus.irq_ack); end
    numCompared++; if (bus.Exc !== 1'b0) begin numMismatched++; $display("[TB] FAIL irq_masked_exc got=%b want=0", bus.Exc); end
    advanceClock();
    applyStimulus(4'd0, 1'b0, 64'h84, 1'b1, 2'd1);
    #2;
    numCompared++; if (bus.Exc !== IRQ_EN) begin numMismatched++; $display("[TB] FAIL irq_take_exc got=%b want=%b", bus.Exc, IRQ_EN); end
    advanceClock();
    applyStimulus(4'd0, 1'b0, 64'hD8, 1'b0, 2'd1);
    #2;
    numCompared++; if (bus.irq_ack !== IRQ_EN) begin numMismatched++; $display("[TB] FAIL irq_ack_pulse got=%b want=%b", bus.irq_ack, IRQ_EN); end
    numCompared++; if (bus.sysreg_rd !== (IRQ_EN ? 64'd1 : 64'd2)) begin numMismatched++; $display("[TB] FAIL irq_esr got=%h want=%h", bus.sysreg_rd, IRQ_EN ? 64'd1 : 64'd2); end
    numCompared++; if (bus.ELR !== (IRQ_EN ? 64'h84 : 64'h80)) begin numMismatched++; $display("[TB] FAIL irq_elr got=%h want=%h", bus.ELR, IRQ_EN ? 64'h84 : 64'h80); end
    advanceClock();
    numCompared++; if (bus.irq_ack !== 1'b0) begin numMismatched++; $display("[TB] FAIL irq_ack_single got=%b want=0", bus.irq_ack); end
  endtask

  task automatic test_double_fault();
    doReset();
    applyStimulus(4'd2, 1'b0, 64'h10, 1'b0, 2'd1);
    advanceClock();
    applyStimulus(4'd2, 1'b0, 64'hD8, 1'b0, 2'd1);
    #2;
    numCompared++; if (bus.Exc !== 1'b1) begin numMismatched++; $display("[TB] FAIL dfault_exc got=%b want=1", bus.Exc); end
    advanceClock();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'($urandom_range(0, 3)), 1'($urandom), 64'hD8, 1'($urandom), 2'd1);
      #2;
      numCompared++; if (bus.Exc !== 1'b1 || bus.ExcFlush !== 1'b1) begin numMismatched++; $display("[TB] FAIL fault_hold cyc=%0d got=%b%b want=11", i, bus.Exc, bus.ExcFlush); end
      numCompared++; if (bus.sysreg_rd !== 64'hF || bus.ELR !== 64'h10 || bus.irq_ack !== 1'b0) begin numMismatched++; $display("[TB] FAIL fault_regs cyc=%0d esr=%h elr=%h ack=%b want f/10/0", i, bus.sysreg_rd, bus.ELR, bus.irq_ack); end
      advanceClock();
    end
    doReset();
    applyStimulus(4'd0, 1'b0, 64'h0, 1'b0, 2'd1);
    #2;
    numCompared++; if (bus.Exc !== 1'b0) begin numMismatched++; $display("[TB] FAIL fault_cleared got=%b want=0", bus.Exc); end
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'd2, 1'b0, 64'(i * 4), 1'b0, 2'd2);
      advanceClock();
      applyStimulus(4'd0, 1'b1, 64'hD8, 1'b0, 2'd2);
      advanceClock();
    end
    applyStimulus(4'd0, 1'b0, 64'h100, 1'b0, 2'd2);
    #2;
    numCompared++; if (bus.sysreg_rd !== 64'd3) begin numMismatched++; $display("[TB] FAIL sat_count got=%h want=3", bus.sysreg_rd); end
    applyStimulus(4'd0, 1'b0, 64'h104, 1'b1, 2'd3);
    #2;
    numCompared++; if (bus.Exc !== IRQ_EN) begin numMismatched++; $display("[TB] FAIL irq_gate_exc got=%b want=%b", bus.Exc, IRQ_EN); end
    numCompared++; if (bus.sysreg_rd !== 64'd0) begin numMismatched++; $display("[TB] FAIL sel_zero got=%h want=0", bus.sysreg_rd); end
    advanceClock();
    numCompared++; if (bus.irq_ack !== IRQ_EN) begin numMismatched++; $display("[TB] FAIL irq_gate_ack got=%b want=%b", bus.irq_ack, IRQ_EN); end
  endtask

  task automatic test_random();
    logic [3:0] es;
    doReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) doReset();
      es = ($urandom_range(0, 99) < 70) ? 4'd0 : 4'($urandom_range(2, 15));
      applyStimulus(es, 1'($urandom_range(0, 99) < 35), {$urandom, $urandom},
                    1'($urandom_range(0, 99) < 25), 2'($urandom));
      #2;
      numCompared++; if (bus.Exc !== expExc() || bus.ExcFlush !== expExc()) begin numMismatched++; $display("[TB] FAIL rnd_exc cyc=%0d got=%b%b want=%b", i, bus.Exc, bus.ExcFlush, expExc()); end
      numCompared++; if (bus.InHandler !== mHandler) begin numMismatched++; $display("[TB] FAIL rnd_inhandler cyc=%0d got=%b want=%b", i, bus.InHandler, mHandler); end
      numCompared++; if (bus.irq_ack !== mAck) begin numMismatched++; $display("[TB] FAIL rnd_ack cyc=%0d got=%b want=%b", i, bus.irq_ack, mAck); end
      numCompared++; if (bus.ELR !== mElr || bus.ESR !== mEsr) begin numMismatched++; $display("[TB] FAIL rnd_regs cyc=%0d elr=%h esr=%h want %h/%h", i, bus.ELR, bus.ESR, mElr, mEsr); end
      numCompared++; if (bus.sysreg_rd !== expSys(bus.sysreg_sel)) begin numMismatched++; $display("[TB] FAIL rnd_sysreg cyc=%0d sel=%0d got=%h want=%h", i, bus.sysreg_sel, bus.sysreg_rd, expSys(bus.sysreg_sel)); end
      advanceClock();
    end
  endtask

  initial begin
    clearModel();
    applyStimulus(4'd0, 1'b0, 64'd0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    test_reset();
    test_sync_exception();
    test_eret();
    test_irq_pending();
    test_double_fault();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
